// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: fixed-latency multiply, 32-step restoring divide, MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ctrl 6..9) accumulating into {hi,lo}.
module muldiv_unit #(
  parameter int MUL_LATENCY = 5,
  parameter int DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;
  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       busy_q;
  logic                       done_q;
  logic [DATA_W-1:0]          hi_q;
  logic [DATA_W-1:0]          lo_q;
  logic [2*DATA_W-1:0]        prod_q;
  logic [DATA_W-1:0]          rem_q;
  logic [DATA_W-1:0]          quo_q;
  logic [DATA_W-1:0]          dvs_q;
  logic [DATA_W-1:0]          araw_q;
  logic                       negq_q;
  logic                       negr_q;
  logic                       div0_q;
`ifdef MULDIV_MADD_EN
  logic [1:0]                 acc_q;
`endif

  logic                       op_mul;
  logic                       op_div;
  logic                       op_sgn;
  logic                       op_mthi;
  logic                       op_mtlo;
  logic [1:0]                 op_acc;

  logic [DATA_W:0]            rem_sh;
  logic [DATA_W-1:0]          rem_d;
  logic [DATA_W-1:0]          quo_d;
  logic [DATA_W-1:0]          div_hi_d;
  logic [DATA_W-1:0]          div_lo_d;
  logic [2*DATA_W-1:0]        mul_res_d;

  function automatic logic [2*DATA_W-1:0] mul64(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn);
    logic signed [2*DATA_W-1:0] sa;
    logic signed [2*DATA_W-1:0] sb;
    sa = $signed({{DATA_W{sgn & a[DATA_W-1]}}, a});
    sb = $signed({{DATA_W{sgn & b[DATA_W-1]}}, b});
    return 64'(sa * sb);
  endfunction

  function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] x, input logic n);
    return n ? (~x + 32'd1) : x;
  endfunction

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    op_acc  = 2'b00;
    case (ctrl)
      4'd0: begin op_mul = 1'b1; op_sgn = 1'b1; end
      4'd1: op_mul = 1'b1;
      4'd2: begin op_div = 1'b1; op_sgn = 1'b1; end
      4'd3: op_div = 1'b1;
      4'd4: op_mthi = 1'b1;
      4'd5: op_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      4'd6: begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 2'b01; end
      4'd7: begin op_mul = 1'b1; op_acc = 2'b01; end
      4'd8: begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 2'b10; end
      4'd9: begin op_mul = 1'b1; op_acc = 2'b10; end
`endif
      default: ;
    endcase
  end

  // One restoring shift-subtract step; the true difference always fits in DATA_W bits.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d = rem_sh[DATA_W-1:0] - dvs_q;
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b0};
    end
    div_lo_d = div0_q ? {DATA_W{1'b1}} : cneg(quo_d, negq_q);
    div_hi_d = div0_q ? araw_q : cneg(rem_d, negr_q);
  end

  always_comb begin
    mul_res_d = prod_q;
`ifdef MULDIV_MADD_EN
    case (acc_q)
      2'b01:   mul_res_d = {hi_q, lo_q} + prod_q;
      2'b10:   mul_res_d = {hi_q, lo_q} - prod_q;
      default: mul_res_d = prod_q;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      araw_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 2'b00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_mul) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(MUL_LATENCY - 1);
              prod_q  <= mul64(A, B, op_sgn);
`ifdef MULDIV_MADD_EN
              acc_q   <= op_acc;
`endif
            end else if (op_div) begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(DIV_LATENCY - 1);
              rem_q   <= '0;
              quo_q   <= cneg(A, op_sgn & A[DATA_W-1]);
              dvs_q   <= cneg(B, op_sgn & B[DATA_W-1]);
              araw_q  <= A;
              div0_q  <= (B == '0);
              negq_q  <= op_sgn & (A[DATA_W-1] ^ B[DATA_W-1]);
              negr_q  <= op_sgn & A[DATA_W-1];
            end else if (op_mthi) begin
              hi_q <= A;
            end else if (op_mtlo) begin
              lo_q <= A;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_res_d;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            hi_q    <= div_hi_d;
            lo_q    <= div_lo_d;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  logic unused_acc;
  assign unused_acc = ^op_acc;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; MADD/MSUB vectors follow MULDIV_MADD_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LATENCY(5), .DIV_LATENCY(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is driven for one cycle; returns at the falling edge of the first cycle after issue.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    ctrl  = c;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    ctrl  = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input int lat,
                     input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(c, a, b);
    wait_idle(n);
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".done"}, {63'd0, done}, 64'd1);
    chk({tag, ".hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, ".lo"}, {32'd0, lo}, {32'd0, el});
    @(negedge clk);
    chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int seen_done;
    int seen_busy;
    reset = 1'b0;
    start = 1'b0;
    ctrl  = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.hi", {32'd0, hi}, 64'd0);
    chk("rst.lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;

    run("mult",     4'd0, 32'hFFFFFFFE, 32'd3,        5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run("multu",    4'd1, 32'hFFFFFFFE, 32'd3,        5, 32'h00000002, 32'hFFFFFFFA);
    run("mult_min", 4'd0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
    run("multu_max",4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run("div",      4'd2, 32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_negb", 4'd2, 32'd7,        32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
    run("divu",     4'd3, 32'd7,        32'd2,        32, 32'd1, 32'd3);
    run("divu_big", 4'd3, 32'hFFFFFFFF, 32'h10,       32, 32'hF, 32'h0FFFFFFF);
    run("divu_z",   4'd3, 32'd5,        32'd0,        32, 32'd5, 32'hFFFFFFFF);
    run("div_z",    4'd2, 32'hFFFFFFFB, 32'd0,        32, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run("div_ovf",  4'd2, 32'h80000000, 32'hFFFFFFFF, 32, 32'd0, 32'h80000000);

    // Asynchronous reset in the middle of a divide.
    issue(4'd4, 32'h55, 32'd0);
    issue(4'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst.busy", {63'd0, busy}, 64'd0);
    chk("arst.done", {63'd0, done}, 64'd0);
    chk("arst.hi", {32'd0, hi}, 64'd0);
    chk("arst.lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
      if (busy === 1'b1) seen_busy++;
    end
    chk("arst.no_done", 64'(seen_done), 64'd0);
    chk("arst.no_busy", 64'(seen_busy), 64'd0);

    // MTLO while a divide is in flight must be dropped.
    issue(4'd5, 32'h77, 32'd0);
    chk("mtlo.lo", {32'd0, lo}, 64'h77);
    issue(4'd3, 32'd9, 32'd2);
    start = 1'b1;
    ctrl  = 4'd5;
    A     = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    ctrl  = 4'd0;
    A     = 32'd0;
    chk("busy_mtlo.lo", {32'd0, lo}, 64'h77);
    wait_idle(n);
    chk("busy_mtlo.lat", 64'(n), 64'd31);
    chk("busy_mtlo.hi", {32'd0, hi}, 64'd1);
    chk("busy_mtlo.res", {32'd0, lo}, 64'd4);

    issue(4'd4, 32'h1234, 32'd0);
    chk("mthi.hi", {32'd0, hi}, 64'h1234);
    chk("mthi.busy", {63'd0, busy}, 64'd0);
    chk("mthi.done", {63'd0, done}, 64'd0);

    issue(4'd12, 32'hAAAA, 32'hBBBB);
    chk("nop.busy", {63'd0, busy}, 64'd0);
    chk("nop.hi", {32'd0, hi}, 64'h1234);
    chk("nop.lo", {32'd0, lo}, 64'd4);

    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd10, 32'd0);
`ifdef MULDIV_MADD_EN
    run("madd",  4'd6, 32'd3, 32'd4, 5, 32'd0, 32'd22);
    run("msubu", 4'd9, 32'd5, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("msub",  4'd8, 32'hFFFFFFFF, 32'd3, 5, 32'd0, 32'd0);
`else
    issue(4'd6, 32'd3, 32'd4);
    chk("madd_off.busy", {63'd0, busy}, 64'd0);
    chk("madd_off.lo", {32'd0, lo}, 64'd10);
    chk("madd_off.hi", {32'd0, hi}, 64'd0);
    @(negedge clk);
    chk("madd_off.done", {63'd0, done}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
